// File: rtl/scb_pkg.sv
// scb_pkg: shared state encoding, record layout and log depth for stream_compare_scoreboard
package scb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  localparam int PC_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int LOG_DEPTH = 8;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [DEF_DATA_W-1:0] data;
  } rec_t;
endpackage

// File: rtl/scb_fifo.sv
// scb_fifo: synchronous FIFO with full/empty, async active-low reset and sync flush
module scb_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/stream_compare_scoreboard.sv
// stream_compare_scoreboard: in-order expected/actual record checker with masked compare and watchdog.
// Defining SCB_ERR_LOG_EN adds an 8-entry circular log of recent mismatches.
module stream_compare_scoreboard
  import scb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int TIMEOUT_CYC = 256,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [31:0]       exp_pc,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  input  logic [31:0]       act_pc,
  input  logic [DATA_W-1:0] act_data,
  input  logic [DATA_W-1:0] cmp_mask,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  orphan_cnt,
  output logic              err_valid,
  output logic [31:0]       err_pc,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_act,
  output logic              timeout,
`ifdef SCB_ERR_LOG_EN
  input  logic [2:0]        log_idx,
  output logic [31:0]       log_pc,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_act,
  output logic [3:0]        log_cnt,
`endif
  output logic [1:0]        state
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 2);
  state_t st, st_n;
  logic full, empty, push, pop, orphan, mis, cnt_en, wd_hit, halt_req;
  logic [PC_W+DATA_W-1:0] head;
  logic [PC_W-1:0] head_pc;
  logic [DATA_W-1:0] head_data;
  logic cmp_v, cmp_mis;
  logic [PC_W-1:0] cmp_pc;
  logic [DATA_W-1:0] cmp_exp, cmp_act;
  logic [WD_W-1:0] wd;
  assign state = st;
  assign {head_pc, head_data} = head;
  assign exp_ready = st == RUN && !full;
  assign push = exp_valid && exp_ready;
  assign pop = st == RUN && act_valid && !empty;
  assign orphan = st == RUN && act_valid && empty;
  assign mis = act_pc != head_pc || |((act_data ^ head_data) & cmp_mask);
  assign cnt_en = cmp_v && st != HALT;
  assign wd_hit = TIMEOUT_CYC != 0 && st == RUN && !empty && !pop && wd == WD_W'(TIMEOUT_CYC - 1);
  assign halt_req = (cnt_en && cmp_mis && STOP_ON_ERR) || wd_hit;
  scb_fifo #(.W(PC_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(clear), .push(push), .pop(pop),
    .din({exp_pc, exp_data}), .dout(head), .full(full), .empty(empty)
  );
  always_comb st_n = clear ? IDLE : (st == HALT || halt_req) ? HALT : enable ? RUN : IDLE;
  // The compare result is staged one cycle before it reaches counters and capture.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cmp_v <= 1'b0;
      cmp_mis <= 1'b0;
      cmp_pc <= '0;
      cmp_exp <= '0;
      cmp_act <= '0;
      wd <= '0;
      match_cnt <= '0;
      mismatch_cnt <= '0;
      orphan_cnt <= '0;
      err_valid <= 1'b0;
      err_pc <= '0;
      err_exp <= '0;
      err_act <= '0;
      timeout <= 1'b0;
    end else begin
      st <= st_n;
      cmp_v <= pop && !clear;
      cmp_mis <= mis;
      cmp_pc <= act_pc;
      cmp_exp <= head_data;
      cmp_act <= act_data;
      wd <= (clear || pop || empty) ? '0 : st == RUN ? wd + 1'b1 : wd;
      if (clear) begin
        match_cnt <= '0;
        mismatch_cnt <= '0;
        orphan_cnt <= '0;
        err_valid <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (orphan && ~&orphan_cnt) orphan_cnt <= orphan_cnt + 1'b1;
        if (cnt_en && !cmp_mis && ~&match_cnt) match_cnt <= match_cnt + 1'b1;
        if (cnt_en && cmp_mis && ~&mismatch_cnt) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (cnt_en && cmp_mis && !err_valid) begin
          err_valid <= 1'b1;
          err_pc <= cmp_pc;
          err_exp <= cmp_exp;
          err_act <= cmp_act;
        end
        if (wd_hit) timeout <= 1'b1;
      end
    end
`ifdef SCB_ERR_LOG_EN
  logic [PC_W-1:0] lpc [LOG_DEPTH];
  logic [DATA_W-1:0] lexp [LOG_DEPTH];
  logic [DATA_W-1:0] lact [LOG_DEPTH];
  logic [2:0] lwp;
  assign log_pc = lpc[log_idx];
  assign log_exp = lexp[log_idx];
  assign log_act = lact[log_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lwp <= '0;
      log_cnt <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        lpc[i] <= '0;
        lexp[i] <= '0;
        lact[i] <= '0;
      end
    end else if (clear) begin
      lwp <= '0;
      log_cnt <= '0;
    end else if (cnt_en && cmp_mis) begin
      lpc[lwp] <= cmp_pc;
      lexp[lwp] <= cmp_exp;
      lact[lwp] <= cmp_act;
      lwp <= lwp + 1'b1;
      if (log_cnt != 4'(LOG_DEPTH)) log_cnt <= log_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_stream_compare_scoreboard.sv
// tb_stream_compare_scoreboard: directed and randomized checks against a queue-based reference model
module tb_stream_compare_scoreboard;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst_n, enable, clear, exp_valid, act_valid, exp_ready, err_valid, timeout;
  logic [31:0] exp_pc, act_pc, err_pc;
  logic [DW-1:0] exp_data, act_data, cmp_mask, err_exp, err_act;
  logic [15:0] match_cnt, mismatch_cnt, orphan_cnt;
  logic [1:0] state;
`ifdef SCB_ERR_LOG_EN
  logic [2:0] log_idx;
  logic [31:0] log_pc;
  logic [DW-1:0] log_exp, log_act;
  logic [3:0] log_cnt;
`endif
  int n_vec = 0;
  int n_mis = 0;
  int m_match = 0;
  int m_mism = 0;
  int m_orph = 0;
  logic [31:0] qpc[$];
  logic [DW-1:0] qd[$];
  logic [DW-1:0] d;
  stream_compare_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc), .exp_data(exp_data),
    .act_valid(act_valid), .act_pc(act_pc), .act_data(act_data), .cmp_mask(cmp_mask),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .orphan_cnt(orphan_cnt),
    .err_valid(err_valid), .err_pc(err_pc), .err_exp(err_exp), .err_act(err_act),
    .timeout(timeout),
`ifdef SCB_ERR_LOG_EN
    .log_idx(log_idx), .log_pc(log_pc), .log_exp(log_exp), .log_act(log_act), .log_cnt(log_cnt),
`endif
    .state(state)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_cnt(input string tag);
    chk({tag, ".match"}, 64'(match_cnt), 64'(m_match));
    chk({tag, ".mismatch"}, 64'(mismatch_cnt), 64'(m_mism));
    chk({tag, ".orphan"}, 64'(orphan_cnt), 64'(m_orph));
  endtask
  task automatic model_zero();
    m_match = 0;
    m_mism = 0;
    m_orph = 0;
    qpc.delete();
    qd.delete();
  endtask
  task automatic push(input logic [31:0] pc, input logic [DW-1:0] dat);
    chk("push.exp_ready", 64'(exp_ready), 64'd1);
    exp_valid = 1'b1;
    exp_pc = pc;
    exp_data = dat;
    tick();
    exp_valid = 1'b0;
    qpc.push_back(pc);
    qd.push_back(dat);
  endtask
  task automatic act(input logic [31:0] pc, input logic [DW-1:0] dat);
    logic [31:0] hp;
    logic [DW-1:0] hd;
    act_valid = 1'b1;
    act_pc = pc;
    act_data = dat;
    tick();
    act_valid = 1'b0;
    if (qpc.size() == 0) m_orph++;
    else begin
      hp = qpc.pop_front();
      hd = qd.pop_front();
      if (hp != pc || ((hd ^ dat) & cmp_mask) != '0) m_mism++;
      else m_match++;
    end
    tick();
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    exp_valid = 1'b0;
    act_valid = 1'b0;
    exp_pc = '0;
    act_pc = '0;
    exp_data = '0;
    act_data = '0;
    cmp_mask = '1;
`ifdef SCB_ERR_LOG_EN
    log_idx = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.exp_ready", 64'(exp_ready), 64'd0);
    chk("rst.err_valid", 64'(err_valid), 64'd0);
    chk("rst.timeout", 64'(timeout), 64'd0);
    chk_cnt("rst");
    enable = 1'b1;
    tick();
    chk("run.state", 64'(state), 64'd1);
    for (int i = 0; i < 4; i++) push(32'(4 * i), {$urandom, $urandom});
    for (int i = 0; i < 4; i++) act(qpc[0], qd[0]);
    chk_cnt("four");
    chk("four.match4", 64'(match_cnt), 64'd4);
    chk("four.state", 64'(state), 64'd1);
    for (int it = 0; it < 20; it++) begin
      int k;
      logic [DW-1:0] m;
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) push($urandom & 32'hFFFF_FFFC, {$urandom, $urandom});
      for (int j = 0; j < k; j++) begin
        m = {$urandom, $urandom};
        cmp_mask = m;
        act(qpc[0], qd[0] ^ ({$urandom, $urandom} & ~m));
      end
      if ($urandom_range(0, 3) == 0) act($urandom, {$urandom, $urandom});
      chk_cnt("rnd");
    end
    cmp_mask = ~(64'd1 << 5);
    d = {$urandom, $urandom};
    push(32'h8, d);
    act(32'h8, d ^ (64'd1 << 5));
    chk_cnt("masked");
    cmp_mask = '1;
    d = {$urandom, $urandom};
    exp_valid = 1'b1;
    exp_pc = 32'h10;
    exp_data = d;
    act_valid = 1'b1;
    act_pc = 32'h10;
    act_data = d;
    tick();
    exp_valid = 1'b0;
    act_valid = 1'b0;
    m_orph++;
    qpc.push_back(32'h10);
    qd.push_back(d);
    tick();
    chk_cnt("orph_push");
    act(32'h10, d);
    chk_cnt("orph_then_match");
    d = {$urandom, $urandom};
    push(32'h8, d);
    act(32'h8, d ^ (64'd1 << 5));
    chk_cnt("mis");
    chk("mis.err_valid", 64'(err_valid), 64'd1);
    chk("mis.err_pc", 64'(err_pc), 64'h8);
    chk("mis.err_exp", err_exp, d);
    chk("mis.err_act", err_act, d ^ (64'd1 << 5));
    chk("mis.state", 64'(state), 64'd2);
    chk("mis.exp_ready", 64'(exp_ready), 64'd0);
    exp_valid = 1'b1;
    act_valid = 1'b1;
    act_pc = 32'h8;
    act_data = d;
    repeat (3) tick();
    exp_valid = 1'b0;
    act_valid = 1'b0;
    chk_cnt("halt_frozen");
    chk("halt.state", 64'(state), 64'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    chk("clr.state", 64'(state), 64'd0);
    chk("clr.err_valid", 64'(err_valid), 64'd0);
    chk_cnt("clr");
    tick();
    chk("wd.run", 64'(state), 64'd1);
    for (int i = 0; i < 8; i++) push(32'(4 * i), {$urandom, $urandom});
    exp_valid = 1'b1;
    chk("full.exp_ready", 64'(exp_ready), 64'd0);
    repeat (248) tick();
    chk("wd.pre_timeout", 64'(timeout), 64'd0);
    chk("wd.pre_state", 64'(state), 64'd1);
    tick();
    exp_valid = 1'b0;
    chk("wd.timeout", 64'(timeout), 64'd1);
    chk("wd.state", 64'(state), 64'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
    chk("wdclr.timeout", 64'(timeout), 64'd0);
    chk("wdclr.state", 64'(state), 64'd0);
    tick();
    act(32'h40, {$urandom, $urandom});
    chk_cnt("flushed");
    for (int i = 0; i < 4; i++) push(32'(4 * i), {$urandom, $urandom});
    for (int i = 0; i < 3; i++) act(qpc[0], qd[0]);
    chk_cnt("pre_rst");
    act_valid = 1'b1;
    act_pc = qpc[0];
    act_data = qd[0];
    tick();
    act_valid = 1'b0;
    enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_zero();
    chk_cnt("async_rst");
    chk("async_rst.state", 64'(state), 64'd0);
    chk("async_rst.exp_ready", 64'(exp_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt("post_rst");
    chk("post_rst.state", 64'(state), 64'd0);
    chk("post_rst.err_valid", 64'(err_valid), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
